sq_meta_rr_arbiter: RTL

SQ_META_RR_ARBITER -- requirements
Module: sq_meta_rr_arbiter

---
 rtl/sq_meta_rr_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sq_meta_rr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ sq_meta AXI-stream requesters into one
// registered output stream toward the RoCE core SQ meta input.
module sq_meta_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 240,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      arb_enable,
  input  logic [NUM_REQ*DATA_W-1:0] s_req_tdata,
  input  logic [NUM_REQ-1:0]        s_req_tvalid,
  output logic [NUM_REQ-1:0]        s_req_tready,
  output logic [DATA_W-1:0]         m_axis_sq_meta_tdata,
  output logic                      m_axis_sq_meta_tvalid,
  input  logic                      m_axis_sq_meta_tready,
  output logic [ID_W-1:0]           m_grant_id,
  output logic [31:0]               beat_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sq_meta_rr_arbiter: NUM_REQ must be in 2..8");
  end
  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("sq_meta_rr_arbiter: ID_W must equal clog2(NUM_REQ)");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                obuf_valid;
  logic [DATA_W-1:0]   obuf_data;
  logic [ID_W-1:0]     obuf_id;
  logic [ID_W-1:0]     rr_ptr;
  logic [31:0]         beat_cnt_q;

  logic                load;
  logic                drain;
  logic [NUM_REQ-1:0]  above_ptr;
  logic [NUM_REQ-1:0]  masked_req;
  logic [ID_W-1:0]     winner;
  logic [DATA_W-1:0]   winner_data;

  // Index of the lowest set bit; callers guarantee at least one bit is set.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  assign obuf_valid = (state_q == FULL);
  assign drain      = obuf_valid & m_axis_sq_meta_tready;
  // Reset gating keeps tready low while the buffer is being cleared.
  assign load       = ap_rst_n & arb_enable & (~obuf_valid | m_axis_sq_meta_tready)
                      & (|s_req_tvalid);

  // Requesters strictly above the last winner get first pick; otherwise wrap
  // to the lowest valid index. Equivalent to a scan from rr_ptr+1 with wrap.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    above_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above_ptr[i] = (ID_W'(i) > rr_ptr);
    end
  end

  assign masked_req = s_req_tvalid & above_ptr;
  assign winner     = (|masked_req) ? lowest_idx(masked_req) : lowest_idx(s_req_tvalid);

  always_comb begin
    winner_data  = '0;
    s_req_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        winner_data     = s_req_tdata[i*DATA_W +: DATA_W];
        s_req_tready[i] = load;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (drain && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!ap_rst_n) state_q <= EMPTY;
    else           state_q <= state_d;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      // NOTE: the wide data register is reset on purpose so a flushed beat can
      // never reappear on the output bus after reset.
      obuf_data <= '0;
      obuf_id   <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
    end else if (load) begin
      obuf_data <= winner_data;
      obuf_id   <= winner;
      rr_ptr    <= winner;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  beat_cnt_q <= '0;
    else if (drain) beat_cnt_q <= beat_cnt_q + 32'd1;
  end

  assign m_axis_sq_meta_tvalid = obuf_valid;
  assign m_axis_sq_meta_tdata  = obuf_data;
  assign m_grant_id            = obuf_id;
  assign beat_count            = beat_cnt_q;

endmodule
